soc_irq_collector: RTL and testbench

Interrupt conditioning stage directly upstream of the PLIC gateways in the SoC top. Collects the `NumSources` peripheral interrupt lines: UART, SPI, Ethernet, Timer and the `IOMMUNumWires` IOMMU wires. Optionally synchronises each line, and presents registered, glitch-free levels to the PLIC. IOMMU wires are pulse-signalled, so pulse sources are latched and re-armed by PLIC completion, and pulses arriving while pending are counted so none are lost.

---
 rtl/soc_irq_collector_pkg.sv | 26 ++
 rtl/soc_irq_collector_tracker.sv | 84 ++++++++
 rtl/soc_irq_collector.sv | 66 ++++++
 tb/tb_soc_irq_collector.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/soc_irq_collector_pkg.sv
// ariane_soc: SoC interrupt map plus the collector's sync and pulse masks
package ariane_soc;

  localparam int NumSources    = 30;
  localparam int IOMMUNumWires = 4;
  localparam int LastIntIndex  = 10;

  localparam int IrqUartIdx   = 0;
  localparam int IrqSpiIdx    = 1;
  localparam int IrqEthIdx    = 2;
  localparam int IrqTimerBase = 3;
  localparam int IrqIommuBase = LastIntIndex - IOMMUNumWires + 1;

  function automatic logic [NumSources-1:0] mask_range(input int lo, input int hi);
    mask_range = '0;
    for (int i = lo; i <= hi; i++) mask_range[i] = 1'b1;
  endfunction

  localparam logic [NumSources-1:0] IrqSyncMask  = mask_range(IrqUartIdx, IrqEthIdx);
  localparam logic [NumSources-1:0] IrqPulseMask = mask_range(IrqIommuBase, LastIntIndex);

  localparam logic [1:0] IrqIdle    = 2'd0;
  localparam logic [1:0] IrqPending = 2'd1;
  localparam logic [1:0] IrqGap     = 2'd2;

endpackage

// File: rtl/soc_irq_collector_tracker.sv
// irq_pulse_tracker: edge-latched interrupt with coalescing counter and post-completion gap
module irq_pulse_tracker
  import ariane_soc::*;
#(
  parameter int CntWidth  = 4,
  parameter int GapCycles = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic edge_i,
  input  logic ack_i,
  output logic irq_o,
  output logic overflow_o
);

  localparam int TmrWidth = GapCycles > 1 ? $clog2(GapCycles) : 1;
  localparam logic [CntWidth-1:0] CntMax  = '1;
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
  localparam logic [TmrWidth-1:0] TmrOne  = TmrWidth'(1);
  localparam logic [TmrWidth-1:0] TmrLoad = TmrWidth'(GapCycles - 1);

  logic [1:0]          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [TmrWidth-1:0] tmr_q, tmr_d;
  logic                ovf_q, ovf_d;
  logic                irq_q;
  logic                count_edge;

  // FSM transitions, gap countdown and coalescing of edges that land while busy
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    ovf_d      = ovf_q;
    count_edge = 1'b0;
    case (state_q)
      IrqIdle: state_d = edge_i ? IrqPending : IrqIdle;
      IrqPending: begin
        count_edge = edge_i;
        if (ack_i) begin
          state_d = IrqGap;
          tmr_d   = TmrLoad;
        end
      end
      IrqGap: begin
        if (tmr_q != '0) begin
          tmr_d      = tmr_q - TmrOne;
          count_edge = edge_i;
        end else if (cnt_q != '0) begin
          state_d = IrqPending;
          cnt_d   = edge_i ? cnt_q : cnt_q - CntOne;
        end else begin
          state_d = edge_i ? IrqPending : IrqIdle;
        end
      end
      default: state_d = IrqIdle;
    endcase
    if (count_edge) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
      ovf_d = ovf_q | (cnt_q == CntMax);
    end
  end

  // state, counter, timer and a registered copy of the PENDING decode for a clean output
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IrqIdle;
      cnt_q   <= '0;
      tmr_q   <= '0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      ovf_q   <= ovf_d;
      irq_q   <= state_d == IrqPending;
    end
  end

  assign irq_o      = irq_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/soc_irq_collector.sv
// soc_irq_collector: synchronises, retimes and pulse-latches peripheral interrupts for the PLIC
module soc_irq_collector #(
  parameter int                          NumSources = ariane_soc::NumSources,
  parameter logic [NumSources-1:0]       SyncMask   = ariane_soc::IrqSyncMask,
  parameter logic [NumSources-1:0]       PulseMask  = ariane_soc::IrqPulseMask,
  parameter int                          CntWidth   = 4,
  parameter int                          GapCycles  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumSources-1:0] irq_i,
  input  logic [NumSources-1:0] ack_i,
  output logic [NumSources-1:0] irq_o,
  output logic [NumSources-1:0] overflow_o
);

  for (genvar i = 0; i < NumSources; i++) begin : g_src
    logic d;
    if (SyncMask[i]) begin : g_sync
      logic s1_q, s2_q;
      // two-flop synchroniser for a line from another clock domain
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          s1_q <= 1'b0;
          s2_q <= 1'b0;
        end else begin
          s1_q <= irq_i[i];
          s2_q <= s1_q;
        end
      end
      assign d = s2_q;
    end else begin : g_nosync
      assign d = irq_i[i];
    end
    if (PulseMask[i]) begin : g_pulse
      logic d_q;
      // previous-cycle level; reset low so a line high at release counts as one edge
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) d_q <= 1'b0;
        else d_q <= d;
      end
      irq_pulse_tracker #(
        .CntWidth (CntWidth),
        .GapCycles(GapCycles)
      ) u_trk (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .edge_i    (d & ~d_q),
        .ack_i     (ack_i[i]),
        .irq_o     (irq_o[i]),
        .overflow_o(overflow_o[i])
      );
    end else begin : g_level
      logic irq_q, unused_ack;
      // level sources are only retimed; completion carries no meaning for them
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) irq_q <= 1'b0;
        else irq_q <= d;
      end
      assign irq_o[i]      = irq_q;
      assign overflow_o[i] = 1'b0;
      assign unused_ack    = ack_i[i];
    end
  end

endmodule

// File: tb/tb_soc_irq_collector.sv
// tb_soc_irq_collector: vector table, corner sequences and randomized run against a behavioural model
module tb_soc_irq_collector;
  import ariane_soc::*;

  localparam int N    = NumSources;
  localparam int G    = 2;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] irq_i = '0;
  logic [N-1:0] ack_i = '0;
  logic [N-1:0] irq_o, overflow_o;

  int n_chk = 0;
  int n_fail = 0;

  logic [N-1:0] h1, h2, dp, m_out, m_ovf;
  int gap [N];
  int owed [N];

  typedef struct {
    logic [N-1:0] irq;
    logic [N-1:0] ack;
    logic [N-1:0] exp;
  } vec_t;
  vec_t tbl [15];

  always #5 clk = ~clk;

  soc_irq_collector dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .irq_i     (irq_i),
    .ack_i     (ack_i),
    .irq_o     (irq_o),
    .overflow_o(overflow_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    h1 = '0;
    h2 = '0;
    dp = '0;
    m_out = '0;
    m_ovf = '0;
    for (int i = 0; i < N; i++) begin
      gap[i] = 0;
      owed[i] = 0;
    end
  endfunction

  function automatic void accept(input int i);
    if (owed[i] == CMAX) m_ovf[i] = 1'b1;
    else owed[i]++;
  endfunction

  // one cycle of the spec rules: d is the raw or 2-cycle-delayed input, output is what shows next cycle
  function automatic void model_step();
    logic [N-1:0] d;
    logic e;
    d = (IrqSyncMask & h2) | (~IrqSyncMask & irq_i);
    for (int i = 0; i < N; i++) begin
      e = d[i] & ~dp[i];
      if (!IrqPulseMask[i]) m_out[i] = d[i];
      else if (m_out[i]) begin
        if (ack_i[i]) begin
          m_out[i] = 1'b0;
          gap[i] = G;
        end
        if (e) accept(i);
      end else if (gap[i] > 1) begin
        gap[i]--;
        if (e) accept(i);
      end else if (gap[i] == 1) begin
        gap[i] = 0;
        if (owed[i] > 0) begin
          m_out[i] = 1'b1;
          owed[i] = owed[i] - 1 + int'(e);
        end else m_out[i] = e;
      end else m_out[i] = e;
    end
    dp = d;
    h2 = h1;
    h1 = irq_i;
  endfunction

  task automatic cyc(input logic [N-1:0] irq, input logic [N-1:0] ack);
    @(posedge clk);
    #1;
    irq_i = irq;
    ack_i = ack;
    @(negedge clk);
    check("model_irq", irq_o, m_out);
    check("model_ovf", overflow_o, m_ovf);
    if (rst) model_reset();
    else model_step();
  endtask

  initial begin
    logic [N-1:0] b8, b9, b10, irq, ack;
    int rises, low_run;
    logic prev;
    b8  = '0; b8[8] = 1'b1;
    b9  = '0; b9[9] = 1'b1;
    b10 = '0; b10[10] = 1'b1;
    tbl[0]  = '{30'h89, 30'h00, 30'h00};
    tbl[1]  = '{30'h09, 30'h08, 30'h88};
    tbl[2]  = '{30'h01, 30'h00, 30'h88};
    tbl[3]  = '{30'h01, 30'h80, 30'h81};
    tbl[4]  = '{30'h00, 30'h00, 30'h01};
    tbl[5]  = '{30'h00, 30'h00, 30'h01};
    tbl[6]  = '{30'h80, 30'h00, 30'h01};
    tbl[7]  = '{30'h80, 30'h80, 30'h80};
    tbl[8]  = '{30'h00, 30'h00, 30'h00};
    tbl[9]  = '{30'h80, 30'h00, 30'h00};
    tbl[10] = '{30'h00, 30'h00, 30'h80};
    tbl[11] = '{30'h00, 30'h80, 30'h80};
    tbl[12] = '{30'h00, 30'h00, 30'h00};
    tbl[13] = '{30'h00, 30'h00, 30'h00};
    tbl[14] = '{30'h00, 30'h00, 30'h00};
    model_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_irq", irq_o, 0);
    check("reset_ovf", overflow_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int t = 0; t < 15; t++) begin
      cyc(tbl[t].irq, tbl[t].ack);
      check($sformatf("tbl_irq[%0d]", t), irq_o, tbl[t].exp);
      check($sformatf("tbl_ovf[%0d]", t), overflow_o, 0);
    end

    rises = 0;
    low_run = 0;
    prev = 1'b0;
    for (int c = 0; c < 60; c++) begin
      irq = (c inside {0, 2, 4, 6}) ? b8 : '0;
      ack = (c inside {10, 20, 30, 40}) ? b8 : '0;
      cyc(irq, ack);
      if (irq_o[8] && !prev) begin
        rises++;
        if (rises > 1) check("coal_gap_len", low_run, G);
      end
      low_run = irq_o[8] ? 0 : low_run + 1;
      prev = irq_o[8];
    end
    check("coal_rises", rises, 4);
    check("coal_idle", irq_o[8], 0);

    for (int c = 0; c <= 36; c++) begin
      cyc((c % 2 == 0 && c <= 34) ? b9 : '0, '0);
      if (c == 32) check("ovf_not_yet", overflow_o[9], 0);
    end
    check("ovf_set", overflow_o[9], 1);
    rises = 0;
    prev = irq_o[9];
    for (int k = 0; k < 64; k++) begin
      cyc('0, (k % 4 == 0) ? b9 : '0);
      if (irq_o[9] && !prev) rises++;
      prev = irq_o[9];
    end
    repeat (6) cyc('0, '0);
    check("sat_rises", rises, CMAX);
    check("sat_idle", irq_o[9], 0);
    check("ovf_sticky", overflow_o[9], 1);

    for (int c = 0; c <= 25; c++) begin
      irq = (c inside {0, 3, 14, 16, 18, 20, 22, 24}) ? b10 : '0;
      ack = (c inside {3, 8}) ? b10 : '0;
      cyc(irq, ack);
      if (c inside {4, 5, 12}) check($sformatf("coinc_low[%0d]", c), irq_o[10], 0);
      if (c inside {6, 25}) check($sformatf("coinc_high[%0d]", c), irq_o[10], 1);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_async_irq", irq_o, 0);
    check("rst_async_ovf", overflow_o, 0);
    model_reset();
    repeat (2) cyc('0, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) cyc('0, '0);
    check("rst_no_reassert", irq_o, 0);

    for (int c = 0; c < 500; c++) begin
      irq = N'($urandom & $urandom);
      ack = N'($urandom) & N'($urandom);
      cyc(irq, ack);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
